// File: rtl/aes_round_sched.sv
// AES-128 iterative round scheduler: applies the key0 whitening on accept, then issues NR
// rounds to an external datapath and returns the ciphertext. Option: AES_SCHED_TIMEOUT_EN (adds err).
module aes_round_sched #(
  parameter int DATA_W    = 128,
  parameter int NR        = 10,
  parameter int ROUND_LAT = 1,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DATA_W-1:0] key0,
  output logic              rnd_valid,
  output logic [DATA_W-1:0] rnd_data,
  output logic [3:0]        rnd_idx,
  output logic              rnd_last,
  input  logic              rnd_valid_out,
  input  logic [DATA_W-1:0] rnd_data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
`ifdef AES_SCHED_TIMEOUT_EN
  output logic              err,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} fsm_t;

  fsm_t              fsm_reg, fsm_next;
  logic [DATA_W-1:0] state_reg, state_next;
  logic [DATA_W-1:0] out_data_reg, out_data_next;
  logic [3:0]        rnd_reg, rnd_next;
  logic              last_round;

  // The round counter is 4 bits wide, so NR must fit; a latency budget cannot be negative.
  if (NR < 1 || NR > 15 || ROUND_LAT < 0 || TIMEOUT < 0) begin : g_cfg_check
    $error("aes_round_sched: unsupported parameter set");
  end

  assign last_round = (rnd_reg == 4'(NR));

`ifdef AES_SCHED_TIMEOUT_EN
  localparam int LIMIT = ROUND_LAT + TIMEOUT;
  localparam int CW    = $clog2(LIMIT + 2);

  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
  logic          timeout;

  // wait_cnt_reg counts completed WAIT cycles, so this fires on WAIT cycle LIMIT+1.
  assign timeout = (fsm_reg == WAIT) && !rnd_valid_out && (wait_cnt_reg == CW'(LIMIT));
  assign err     = timeout;

  always_comb begin
    wait_cnt_next = '0;
    if (fsm_reg == WAIT) wait_cnt_next = wait_cnt_reg + CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wait_cnt_reg <= '0;
    else        wait_cnt_reg <= wait_cnt_next;
  end
`endif

  always_comb begin
    fsm_next      = fsm_reg;
    state_next    = state_reg;
    rnd_next      = rnd_reg;
    out_data_next = out_data_reg;
    case (fsm_reg)
      IDLE: begin
        if (in_valid) begin
          state_next = in_data ^ key0;
          rnd_next   = 4'd1;
          fsm_next   = ISSUE;
        end
      end
      ISSUE: fsm_next = WAIT;
      WAIT: begin
        if (rnd_valid_out) begin
          state_next = rnd_data_out;
          if (last_round) begin
            out_data_next = rnd_data_out;
            fsm_next      = DONE;
          end else begin
            rnd_next = rnd_reg + 4'd1;
            fsm_next = ISSUE;
          end
        end
`ifdef AES_SCHED_TIMEOUT_EN
        else if (timeout) begin
          fsm_next = IDLE;
        end
`endif
      end
      DONE: begin
        if (out_ready) fsm_next = IDLE;
      end
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_reg      <= IDLE;
      state_reg    <= '0;
      out_data_reg <= '0;
      rnd_reg      <= '0;
    end else begin
      fsm_reg      <= fsm_next;
      state_reg    <= state_next;
      out_data_reg <= out_data_next;
      rnd_reg      <= rnd_next;
    end
  end

  assign in_ready  = (fsm_reg == IDLE);
  assign rnd_valid = (fsm_reg == ISSUE);
  assign rnd_data  = state_reg;
  assign rnd_idx   = rnd_reg;
  assign rnd_last  = rnd_valid && last_round;
  assign out_valid = (fsm_reg == DONE);
  assign out_data  = out_data_reg;
  assign busy      = (fsm_reg != IDLE);

endmodule

// File: tb/tb_aes_round_sched.sv
// Bench for aes_round_sched: behavioural datapath (test XOR round or full AES round) plus
// a protocol-level reference that checks every output on every cycle.
module tb_aes_round_sched;
  localparam int NR        = 10;
  localparam int ROUND_LAT = 1;
  localparam int TIMEOUT   = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready;
  logic [127:0] in_data, key0;
  logic         rnd_valid, rnd_last;
  logic [127:0] rnd_data;
  logic [3:0]   rnd_idx;
  logic         rnd_valid_out;
  logic [127:0] rnd_data_out;
  logic         out_valid, out_ready;
  logic [127:0] out_data;
  logic         busy;
`ifdef AES_SCHED_TIMEOUT_EN
  logic         err;
`endif

  logic         rvo_resp = 1'b0, rvo_spur = 1'b0;
  logic [127:0] resp_data = '0, spur_data = '0;
  assign rnd_valid_out = rvo_resp | rvo_spur;
  assign rnd_data_out  = rvo_spur ? spur_data : resp_data;

  int checks = 0, failures = 0, cyc = 0;
  bit dp_aes = 1'b0;
  int lat_mode = 0;
  int silent_round = 0;
  logic [7:0]   sbox [256];
  logic [127:0] rkeys [11];
  logic [31:0]  w [44];

  aes_round_sched dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .key0(key0),
    .rnd_valid(rnd_valid), .rnd_data(rnd_data), .rnd_idx(rnd_idx), .rnd_last(rnd_last),
    .rnd_valid_out(rnd_valid_out), .rnd_data_out(rnd_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
`ifdef AES_SCHED_TIMEOUT_EN
    .err(err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [15:0] t;
    t = {v, v};
    return t[15-n -: 8];
  endfunction

  // One AES encryption round on a big-endian 128-bit block (byte 0 = bits 127:120, column-major).
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] rk, input logic last);
    logic [7:0] a [16];
    logic [7:0] b [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) b[rr+4*c] = a[rr+4*((c+rr)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
        b[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        b[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        b[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        b[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r ^ rk;
  endfunction

  // Expected result for the test datapath: each round XORs its index into every byte.
  function automatic logic [127:0] xor_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [127:0] s;
    s = pt ^ k;
    for (int i = 1; i <= NR; i++) s = s ^ {16{4'h0, 4'(i)}};
    return s;
  endfunction

  function automatic int lat_pat(input logic [3:0] idx);
    case ((int'(idx) - 1) % 3)
      0:       return 1;
      1:       return 3;
      default: return 2;
    endcase
  endfunction

  // Round datapath responder.
  initial begin : responder
    logic [127:0] d;
    logic [3:0]   idx;
    logic         last;
    int           lat;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && rnd_valid === 1'b1 && int'(rnd_idx) != silent_round) begin
        d = rnd_data; idx = rnd_idx; last = rnd_last;
        lat = (lat_mode == 0) ? 1 : lat_pat(idx);
        repeat (lat) @(posedge clk);
        #1;
        resp_data = dp_aes ? aes_round(d, rkeys[idx], last) : (d ^ {16{4'h0, idx}});
        rvo_resp  = 1'b1;
        @(posedge clk);
        #1 rvo_resp = 1'b0;
      end
    end
  end

  // Protocol-level reference: tracks which handshake step is due and what value it carries.
  initial begin : model
    bit m_busy, m_issue, m_wait, m_out, exp_err;
    int m_rnd, m_wcnt;
    logic [127:0] m_state, m_cipher;
    m_busy = 0; m_issue = 0; m_wait = 0; m_out = 0; m_rnd = 0; m_wcnt = 0;
    m_state = '0; m_cipher = '0;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_rnd_valid", 128'(rnd_valid), 128'(0));
        chk("rst_rnd_last", 128'(rnd_last), 128'(0));
        chk("rst_rnd_idx", 128'(rnd_idx), 128'(0));
        chk("rst_rnd_data", rnd_data, 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        m_busy = 0; m_issue = 0; m_wait = 0; m_out = 0; m_rnd = 0; m_wcnt = 0;
      end else begin
        exp_err = 0;
`ifdef AES_SCHED_TIMEOUT_EN
        if (m_wait && !rnd_valid_out && (m_wcnt + 1 == ROUND_LAT + TIMEOUT + 1)) exp_err = 1;
        chk("err", 128'(err), 128'(exp_err));
`endif
        chk("busy", 128'(busy), 128'(m_busy));
        chk("in_ready", 128'(in_ready), 128'(!m_busy));
        chk("rnd_valid", 128'(rnd_valid), 128'(m_issue));
        chk("out_valid", 128'(out_valid), 128'(m_out));
        if (m_issue) begin
          chk("rnd_idx", 128'(rnd_idx), 128'(m_rnd));
          chk("rnd_data", rnd_data, m_state);
          chk("rnd_last", 128'(rnd_last), 128'(m_rnd == NR));
        end else begin
          chk("rnd_last_quiet", 128'(rnd_last), 128'(0));
        end
        if (m_out) chk("out_data", out_data, m_cipher);
        if (!m_busy) begin
          if (in_valid) begin
            m_busy = 1; m_issue = 1; m_rnd = 1; m_state = in_data ^ key0;
          end
        end else if (m_issue) begin
          m_issue = 0; m_wait = 1; m_wcnt = 0;
        end else if (m_wait) begin
          if (rnd_valid_out) begin
            m_state = rnd_data_out; m_wait = 0;
            if (m_rnd == NR) begin
              m_cipher = rnd_data_out; m_out = 1;
            end else begin
              m_rnd++; m_issue = 1;
            end
          end else if (exp_err) begin
            m_wait = 0; m_busy = 0;
          end else begin
            m_wcnt++;
          end
        end else if (m_out && out_ready) begin
          m_out = 0; m_busy = 0;
        end
      end
    end
  end

  task automatic wait_accept(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    chk(name, 128'(in_ready), 128'(1));
  endtask

  task automatic wait_out(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 500) begin @(negedge clk); n++; end
    chk(name, 128'(out_valid), 128'(1));
  endtask

  task automatic drain();
    @(posedge clk); #1 out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("drain_out_valid", 128'(out_valid), 128'(0));
    chk("drain_in_ready", 128'(in_ready), 128'(1));
  endtask

  task automatic run_block(input logic [127:0] pt, input logic [127:0] k, input logic [127:0] exp,
                           input int exp_lat, input int hold, input bit spur);
    int t0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = pt; key0 = k;
    wait_accept("accept");
    t0 = cyc;
    @(posedge clk); #1 in_valid = 1'b0;
    wait_out("out_valid_rise");
    chk("latency", 128'(cyc - t0), 128'(exp_lat));
    chk("cipher", out_data, exp);
    $display("block pt=%h key=%h out=%h latency=%0d", pt, k, out_data, cyc - t0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      rvo_spur  = spur && (i == 2);
      spur_data = 128'hdeadbeef_cafef00d_01234567_89abcdef;
      @(negedge clk);
      chk("bp_out_valid", 128'(out_valid), 128'(1));
      chk("bp_out_data", out_data, exp);
      chk("bp_in_ready", 128'(in_ready), 128'(0));
    end
    @(posedge clk); #1 rvo_spur = 1'b0;
    @(negedge clk);
    drain();
  endtask

  initial begin : main
    logic [127:0] pa, ka, pb, kb, fpt, fkey, fct;
    logic [31:0]  t;
    logic [7:0]   inv, rc;
    int           t_iss, n;
    in_valid = 1'b0; in_data = '0; key0 = '0; out_ready = 1'b0; reset = 1'b0;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
    fpt  = 128'h00112233445566778899aabbccddeeff;
    fkey = 128'h000102030405060708090a0b0c0d0e0f;
    fct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    for (int i = 0; i < 4; i++) w[i] = fkey[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 11; k++) rkeys[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    chk("model_sbox53", 128'(sbox[8'h53]), 128'(8'hed));
    chk("model_rkey10", rkeys[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
    chk("model_xor_ref", xor_ref('0, '0), {16{8'h0B}});

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Test datapath, all-zero block, nominal latency.
    run_block('0, '0, {16{8'h0B}}, 21, 0, 0);

    // Spurious result strobe while idle.
    @(posedge clk); #1 rvo_spur = 1'b1; spur_data = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    @(posedge clk); #1 rvo_spur = 1'b0;
    @(negedge clk);
    chk("spur_idle_busy", 128'(busy), 128'(0));
    chk("spur_idle_rnd_idx", 128'(rnd_idx), 128'(NR));
    chk("spur_idle_out_data", out_data, {16{8'h0B}});

    // FIPS-197 C.1 through the real round function.
    dp_aes = 1'b1;
    run_block(fpt, fkey, fct, 21, 0, 0);
    dp_aes = 1'b0;

    // Back-pressure with a spurious strobe in DONE.
    pa = 128'h0123456789abcdeffedcba9876543210;
    ka = 128'h0f0e0d0c0b0a09080706050403020100;
    run_block(pa, ka, xor_ref(pa, ka), 21, 5, 1);

    // in_valid held through DONE: next block only after the output handshake.
    pb = 128'hffeeddccbbaa99887766554433221100;
    kb = 128'h55aa55aa55aa55aa55aa55aa55aa55aa;
    @(posedge clk); #1 in_valid = 1'b1; in_data = pa; key0 = ka;
    wait_accept("blkA_accept");
    @(posedge clk); #1 in_data = pb; key0 = kb;
    wait_out("blkA_out");
    chk("blkA_data", out_data, xor_ref(pa, ka));
    repeat (5) begin
      @(posedge clk); @(negedge clk);
      chk("hold_in_ready", 128'(in_ready), 128'(0));
      chk("hold_out_data", out_data, xor_ref(pa, ka));
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    chk("hs_in_ready", 128'(in_ready), 128'(0));
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("post_hs_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk("blkB_busy", 128'(busy), 128'(1));
    wait_out("blkB_out");
    chk("blkB_data", out_data, xor_ref(pb, kb));
    $display("block pt=%h key=%h out=%h (queued behind back-pressure)", pb, kb, out_data);
    drain();

    // Variable datapath latency 1,3,2 per round: sum(L)=19 -> 19+10+1 cycles.
    lat_mode = 1;
    run_block('0, '0, {16{8'h0B}}, 30, 0, 0);
    lat_mode = 0;

    // Reset during the WAIT of round 5.
    @(posedge clk); #1 in_valid = 1'b1; in_data = pa; key0 = ka;
    wait_accept("rst_blk_accept");
    @(posedge clk); #1 in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(rnd_valid && rnd_idx == 4'd5) && n < 200) begin @(negedge clk); n++; end
    chk("rst_round5_seen", 128'(rnd_idx), 128'(5));
    @(posedge clk); #2 reset = 1'b0;
    #1;
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_rnd_idx", 128'(rnd_idx), 128'(0));
    $display("reset asserted during round 5 wait");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 rvo_spur = 1'b1;
    @(posedge clk); #1 rvo_spur = 1'b0;
    @(negedge clk);
    chk("postrst_spur_busy", 128'(busy), 128'(0));
    chk("postrst_spur_rnd_idx", 128'(rnd_idx), 128'(0));
    run_block(pb, kb, xor_ref(pb, kb), 21, 0, 0);

`ifdef AES_SCHED_TIMEOUT_EN
    // Datapath silent in round 3: err on the 18th WAIT cycle, block dropped.
    silent_round = 3;
    @(posedge clk); #1 in_valid = 1'b1; in_data = pa; key0 = ka;
    wait_accept("to_accept");
    @(posedge clk); #1 in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(rnd_valid && rnd_idx == 4'd3) && n < 200) begin @(negedge clk); n++; end
    t_iss = cyc;
    n = 0;
    @(negedge clk);
    while (!err && n < 100) begin @(negedge clk); n++; end
    chk("to_err_seen", 128'(err), 128'(1));
    chk("to_err_cycle", 128'(cyc - t_iss), 128'(ROUND_LAT + TIMEOUT + 1));
    @(negedge clk);
    chk("to_busy", 128'(busy), 128'(0));
    chk("to_out_valid", 128'(out_valid), 128'(0));
    $display("timeout err after %0d wait cycles", cyc - t_iss - 1);
    silent_round = 0;
    run_block(pb, kb, xor_ref(pb, kb), 21, 0, 0);
`else
    t_iss = 0;
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
